// File: rtl/d2d_sb_link.sv
// Die-to-die sideband link: bring-up FSM, serial frame transmitter and
// receiver, with far-side inputs resynchronised into the clk domain.
module d2d_sb_link #(
  parameter int SR_LEN  = 40,
  parameter int CLK_DIV = 4,
  parameter int RST_CYC = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              link_en,
  input  logic [SR_LEN-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [SR_LEN-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_len_err,
  output logic              link_up,
  output logic              link_err,
  output logic              ns_sr_clk,
  output logic              ns_sr_data,
  output logic              ns_sr_load,
  output logic              ns_mac_rdy,
  output logic              ns_adapter_rstn,
  input  logic              fs_sr_clk,
  input  logic              fs_sr_data,
  input  logic              fs_sr_load,
  input  logic              fs_mac_rdy
);

  localparam int HALF    = CLK_DIV / 2;
  localparam int PH_W    = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(SR_LEN + 2);
  localparam int TMR_MAX = (RST_CYC > TIMEOUT) ? RST_CYC : TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_WAIT, S_UP, S_ERR} state_t;

  state_t             state_reg, state_next;
  logic [TMR_W-1:0]   tmr_reg;
  logic [3:0]         sync1_reg, sync2_reg;
  logic               clk_d_reg, rise_reg, load_d_reg, data_d_reg;
  logic               tx_busy_reg;
  logic [SR_LEN-1:0]  tx_shift_reg;
  logic [BIT_W-1:0]   tx_bit_reg;
  logic [PH_W-1:0]    tx_ph_reg;
  logic [SR_LEN-1:0]  rx_shift_reg, rx_data_reg;
  logic [BIT_W-1:0]   rx_cnt_reg;
  logic               rx_valid_reg, rx_len_err_reg;
  logic               fs_rdy_s, tx_on;

  // Two-flop synchronisers for all far-side inputs: {mac_rdy, load, data, clk}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {fs_mac_rdy, fs_sr_load, fs_sr_data, fs_sr_clk};
      sync2_reg <= sync1_reg;
    end
  end

  assign fs_rdy_s = sync2_reg[3];

  // Registered rising-edge detect of the synced far clock, with load/data aligned to it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_d_reg  <= 1'b0;
      rise_reg   <= 1'b0;
      load_d_reg <= 1'b0;
      data_d_reg <= 1'b0;
    end else begin
      clk_d_reg  <= sync2_reg[0];
      rise_reg   <= sync2_reg[0] & ~clk_d_reg;
      load_d_reg <= sync2_reg[2];
      data_d_reg <= sync2_reg[1];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Dwell timer for RST and WAIT; restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      tmr_reg <= '0;
    else if (state_next != state_reg)                tmr_reg <= '0;
    else if (state_reg == S_RST || state_reg == S_WAIT) tmr_reg <= tmr_reg + 1'b1;
  end

  // FSM next-state logic; link_en low overrides everything
  always_comb begin
    state_next = state_reg;
    if (!link_en) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  state_next = S_RST;
        S_RST:   if (tmr_reg == TMR_W'(RST_CYC - 1)) state_next = S_WAIT;
        S_WAIT:  if (fs_rdy_s) state_next = S_UP;
                 else if (tmr_reg == TMR_W'(TIMEOUT - 1)) state_next = S_ERR;
        S_UP:    if (!fs_rdy_s) state_next = S_WAIT;
        S_ERR:   state_next = S_ERR;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the current state
  always_comb begin
    ns_adapter_rstn = 1'b0;
    ns_mac_rdy      = 1'b0;
    link_up         = 1'b0;
    link_err        = 1'b0;
    case (state_reg)
      S_WAIT: begin ns_adapter_rstn = 1'b1; ns_mac_rdy = 1'b1; end
      S_UP:   begin ns_adapter_rstn = 1'b1; ns_mac_rdy = 1'b1; link_up = 1'b1; end
      S_ERR:  begin ns_adapter_rstn = 1'b1; link_err = 1'b1; end
      default: ;
    endcase
  end

  // Transmitter: SR_LEN data periods then one load period; leaving UP drops the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_reg  <= 1'b0;
      tx_shift_reg <= '0;
      tx_bit_reg   <= '0;
      tx_ph_reg    <= '0;
    end else if (state_reg != S_UP) begin
      tx_busy_reg <= 1'b0;
    end else if (!tx_busy_reg && tx_valid) begin
      tx_busy_reg  <= 1'b1;
      tx_shift_reg <= tx_data;
      tx_bit_reg   <= '0;
      tx_ph_reg    <= '0;
    end else if (tx_busy_reg) begin
      if (tx_ph_reg == PH_W'(CLK_DIV - 1)) begin
        tx_ph_reg    <= '0;
        tx_shift_reg <= {tx_shift_reg[SR_LEN-2:0], 1'b0};
        if (tx_bit_reg == BIT_W'(SR_LEN)) tx_busy_reg <= 1'b0;
        else                              tx_bit_reg  <= tx_bit_reg + 1'b1;
      end else begin
        tx_ph_reg <= tx_ph_reg + 1'b1;
      end
    end
  end

  // Line outputs are gated by UP so a drop silences them in the very next cycle
  assign tx_on      = tx_busy_reg && (state_reg == S_UP);
  assign tx_ready   = (state_reg == S_UP) && !tx_busy_reg;
  assign ns_sr_clk  = tx_on && (tx_ph_reg >= PH_W'(HALF));
  assign ns_sr_load = tx_on && (tx_bit_reg == BIT_W'(SR_LEN));
  assign ns_sr_data = tx_on && (tx_bit_reg != BIT_W'(SR_LEN)) && tx_shift_reg[SR_LEN-1];

  // Receiver: shift on far clock edges, check length on load, quiet outside UP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift_reg   <= '0;
      rx_data_reg    <= '0;
      rx_cnt_reg     <= '0;
      rx_valid_reg   <= 1'b0;
      rx_len_err_reg <= 1'b0;
    end else begin
      rx_valid_reg   <= 1'b0;
      rx_len_err_reg <= 1'b0;
      if (state_reg != S_UP) begin
        rx_cnt_reg <= '0;
      end else if (rise_reg) begin
        if (!load_d_reg) begin
          rx_shift_reg <= {rx_shift_reg[SR_LEN-2:0], data_d_reg};
          if (rx_cnt_reg != BIT_W'(SR_LEN + 1)) rx_cnt_reg <= rx_cnt_reg + 1'b1;
        end else begin
          if (rx_cnt_reg == BIT_W'(SR_LEN)) begin
            rx_data_reg  <= rx_shift_reg;
            rx_valid_reg <= 1'b1;
          end else begin
            rx_len_err_reg <= 1'b1;
          end
          rx_cnt_reg <= '0;
        end
      end
    end
  end

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign rx_len_err = rx_len_err_reg;

endmodule
